// File: rtl/lake_chan_pipe_pkg.sv
// Shared types and sizing helpers for the Lake multi-channel data pipe.
package lake_chan_pipe_pkg;

  // Per-channel operating mode.
  typedef enum logic [1:0] {
    S_BUF   = 2'd0,
    S_DRAIN = 2'd1,
    S_BYP   = 2'd2
  } chan_state_t;

  // Width of a FIFO pointer addressing 0..depth-1 (at least one bit).
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? int'($clog2(depth)) : 1;
  endfunction

  // Width of an occupancy counter holding 0..depth.
  function automatic int unsigned occ_w(input int unsigned depth);
    return int'($clog2(depth + 1));
  endfunction

endpackage

// File: rtl/lake_chan_fifo.sv
// One channel of the Lake pipe: elastic FIFO with buffered/drain/bypass modes.
// The optional handshake counter is present when LAKE_CHAN_PIPE_STATS_EN is defined.
module lake_chan_fifo
  import lake_chan_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned DEPTH      = 2
`ifdef LAKE_CHAN_PIPE_STATS_EN
  , parameter int unsigned CNT_W    = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_bypass,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_full,
  output logic                  o_empty
`ifdef LAKE_CHAN_PIPE_STATS_EN
  , output logic [CNT_W-1:0]    o_xfer_cnt
`endif
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned OCC_W = occ_w(DEPTH);

  chan_state_t           state_q, state_d;
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [OCC_W-1:0]      count_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  push, pop, full, empty, last_word;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (count_q == OCC_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign last_word = (count_q == OCC_W'(1));
  assign o_full    = full;
  assign o_empty   = empty || (state_q == S_BYP);

  // Mode state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_BUF;
    else        state_q <= state_d;
  end

  // Next mode, handshake outputs and FIFO push/pop strobes.
  always_comb begin
    state_d    = state_q;
    o_ready    = 1'b0;
    o_valid    = !empty;
    o_data_out = mem_q[head_q];
    push       = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      S_BUF: begin
        o_ready = !full;
        push    = i_valid && !full;
        pop     = !empty && i_ready;
        // Go straight to bypass only if nothing remains buffered after this edge.
        if (i_bypass) begin
          if (!push && (empty || (last_word && pop))) state_d = S_BYP;
          else                                       state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        pop = !empty && i_ready;
        if (!i_bypass)                       state_d = S_BUF;
        else if (empty || (last_word && pop)) state_d = S_BYP;
      end
      S_BYP: begin
        o_ready    = i_ready;
        o_valid    = i_valid;
        o_data_out = i_data_in;
        if (!i_bypass) state_d = S_BUF;
      end
      default: state_d = S_BUF;
    endcase
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[tail_q] <= i_data_in;
        tail_q        <= next_ptr(tail_q);
      end
      if (pop) head_q <= next_ptr(head_q);
      if (push && !pop)      count_q <= count_q + OCC_W'(1);
      else if (pop && !push) count_q <= count_q - OCC_W'(1);
    end
  end

`ifdef LAKE_CHAN_PIPE_STATS_EN
  logic [CNT_W-1:0] xfer_q;

  // Saturating count of downstream handshakes in every mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   xfer_q <= '0;
    else if (o_valid && i_ready && (xfer_q != '1)) xfer_q <= xfer_q + CNT_W'(1);
  end

  assign o_xfer_cnt = xfer_q;
`else
  // Without statistics the channel carries no counter.
`endif

endmodule

// File: rtl/lake_chan_pipe.sv
// Lake multi-channel data pipe: NUM_CHAN independent elastic channels.
// Optional per-channel transfer counters: define LAKE_CHAN_PIPE_STATS_EN.
module lake_chan_pipe
  import lake_chan_pipe_pkg::*;
#(
  parameter int unsigned NUM_CHAN   = 2,
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CHAN-1:0]            i_bypass,
  input  logic [NUM_CHAN*DATA_WIDTH-1:0] i_data_in,
  input  logic [NUM_CHAN-1:0]            i_valid,
  output logic [NUM_CHAN-1:0]            o_ready,
  output logic [NUM_CHAN*DATA_WIDTH-1:0] o_data_out,
  output logic [NUM_CHAN-1:0]            o_valid,
  input  logic [NUM_CHAN-1:0]            i_ready,
  output logic [NUM_CHAN-1:0]            o_full,
  output logic [NUM_CHAN-1:0]            o_empty
`ifdef LAKE_CHAN_PIPE_STATS_EN
  , output logic [NUM_CHAN*CNT_W-1:0]    o_xfer_cnt
`endif
);

  // One channel instance per bus slice.
  for (genvar c = 0; c < int'(NUM_CHAN); c++) begin : g_chan
    lake_chan_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
`ifdef LAKE_CHAN_PIPE_STATS_EN
      , .CNT_W    (CNT_W)
`endif
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_bypass   (i_bypass[c]),
      .i_data_in  (i_data_in[c*DATA_WIDTH +: DATA_WIDTH]),
      .i_valid    (i_valid[c]),
      .o_ready    (o_ready[c]),
      .o_data_out (o_data_out[c*DATA_WIDTH +: DATA_WIDTH]),
      .o_valid    (o_valid[c]),
      .i_ready    (i_ready[c]),
      .o_full     (o_full[c]),
      .o_empty    (o_empty[c])
`ifdef LAKE_CHAN_PIPE_STATS_EN
      , .o_xfer_cnt (o_xfer_cnt[c*CNT_W +: CNT_W])
`endif
    );
  end

`ifdef LAKE_CHAN_PIPE_STATS_EN
`else
  // Counter width only matters when statistics are built in.
  if (CNT_W == 0) begin : g_no_cnt
  end
`endif

endmodule
